// File: rtl/div_unit_if.sv
// Start/done handshake between the control unit (master) and the divider (slave).
// Operands travel with start; results, busy and flags travel back.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, A, B,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider, one quotient bit per cycle; done pulses WIDTH+1 cycles after accept.
// No backpressure: start is only sampled in IDLE and is dropped while busy.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clock,
    input  logic        reset,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] magb_q, magb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic             accept, b_zero;
    logic [WIDTH:0]   trial;

    // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    assign accept = (state_q == IDLE) && bus.start;
    assign b_zero = (bus.B == '0);
    assign trial  = {1'b0, rem_q[WIDTH-2:0], quo_q[WIDTH-1]} - {1'b0, magb_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !b_zero) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        magb_d = magb_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sa_d   = bus.A[WIDTH-1];
                    sb_d   = bus.B[WIDTH-1];
                    magb_d = mag(bus.B);
                    dz_d   = b_zero;
                    if (b_zero) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        rem_d  = '0;
                        quo_d  = mag(bus.A);
                        cnt_d  = CNT_W'(WIDTH);
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            FIX: begin
                // Truncating division: remainder follows the dividend's sign.
                lo_d   = (sa_q ^ sb_q) ? (~quo_q + ONE) : quo_q;
                hi_d   = sa_q ? (~rem_q + ONE) : rem_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            magb_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            magb_q <= magb_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the datapath's DIV instruction.
- It is the responder end of the start/stop handshake the control unit drives.
- The control unit pulses start with operands from the A/B registers. The unit iterates one quotient bit per cycle, then presents remainder on HI and quotient on LO with a one-cycle done pulse.
- The control unit waits in its DIV state for done, then loads the HI/LO registers.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately.
- start, input, 1, request pulse; sampled only in IDLE.
- A, input, WIDTH, dividend, two's complement; captured on the accepted start edge.
- B, input, WIDTH, divisor, two's complement; captured on the accepted start edge.
- HI, output, WIDTH, remainder, registered.
- LO, output, WIDTH, quotient, registered.
- busy, output, 1, high from the accept edge until the result edge.
- done, output, 1, registered single-cycle completion pulse.
- div_zero, output, 1, high when the last accepted request had B==0.

Behaviour:
- Reset, asynchronous on reset low:
  - State goes to IDLE.
  - HI=0, LO=0, busy=0, done=0, div_zero=0.
  - Counter and internal registers are cleared.
  - Reset mid-operation aborts the division; no done pulse is produced for it.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Capture sA=A[WIDTH-1] and sB=B[WIDTH-1].
  - Capture magA=|A| and magB=|B| as unsigned WIDTH-bit values (|0x80000000| = 0x80000000).
  - Clear div_zero.
- IDLE, divide by zero (B==0 at E0):
  - Set div_zero=1 and done=1 at E0; stay in IDLE; busy stays 0.
  - HI/LO keep their previous values. Done therefore lasts for the cycle after E0.
- IDLE, B!=0 at E0:
  - busy=1, rem=0, quo=magA, cnt=WIDTH, next state CALC.
- CALC, restoring step per edge:
  - t = {rem[WIDTH-2:0], quo[WIDTH-1]} - magB, computed at WIDTH+1 bits.
  - If t is non-negative: rem=t[WIDTH-1:0] and quo={quo[WIDTH-2:0],1}.
  - Otherwise: rem={rem[WIDTH-2:0],quo[WIDTH-1]} and quo={quo[WIDTH-2:0],0}.
  - cnt decrements each edge. When cnt reaches 1 at an edge, next state is FIX, so CALC occupies exactly WIDTH edges (E1..E32).
- FIX at edge E33:
  - LO = quo, negated (two's complement) when sA^sB.
  - HI = rem, negated when sA.
  - Semantics: truncation toward zero; the remainder takes the dividend's sign.
  - done=1, busy=0, next state IDLE.
- Latency: done is high in the cycle following E(WIDTH+1), i.e. 33 cycles after the accept edge for WIDTH=32.
- done pulse:
  - Exactly one cycle; cleared on the next edge unless a new divide-by-zero sets it again.
- HI/LO hold:
  - Stable from the done cycle until the next completed operation.
  - Not disturbed during CALC: iteration uses internal rem/quo registers only.
- Start rules:
  - start while busy (CALC/FIX) is ignored, and the operands are not re-sampled.
  - start in the done cycle (state already IDLE) is accepted, so back-to-back operations are allowed.
- Overflow case:
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0. No flag is raised; this matches MIPS, where the result is undefined and we fix it to this value.
- A=0: LO=0, HI=0, full latency.

Test Plan:
- A=7, B=2, 1-cycle start -> busy for 33 cycles, done pulse 33 cycles after the accept edge, LO=3, HI=1, div_zero=0.
- A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then A=7, B=-2 -> LO=0xFFFFFFFD, HI=1. Then A=-7, B=-2 -> LO=3, HI=0xFFFFFFFF.
- Prior result LO=3, HI=1; then A=5, B=0 -> div_zero=1 and done high in the next cycle, busy never high, HI=1/LO=3 unchanged. A following valid start clears div_zero.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then A=0xFFFFFFFF, B=0x80000000 -> LO=0, HI=0xFFFFFFFF.
- Start A=100, B=7; at cycle 5 pulse start with A=1, B=1 -> ignored, result LO=14, HI=2. Assert start again during the done cycle with A=9, B=3 -> accepted, LO=3, HI=0 after 33 more cycles.
- Start A=100, B=7; drive reset low at cycle 10, not aligned to a clock edge -> HI, LO, busy, done and div_zero are all 0 immediately, and no done pulse follows. After release, A=100, B=7 completes normally with LO=14, HI=2.
